// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mult_state_t;

   // Every iteration moves the operands by exactly one bit position.
   localparam int MULT_SHAMT_ONE = 1;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle of the multiplier; master issues operands, slave computes.
// Handshake: an operation is accepted on a rising edge where start=1 and ready=1; done pulses one cycle with result valid.
interface shift_add_multiplier_if #(
   parameter int N = 32
);
   import mult_pkg::*;

   logic             start;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [2*N-1:0]   result;
   mult_state_t      state;

   modport master (
      output start, a, b,
      input  ready, busy, done, result, state
   );

   modport slave (
      input  start, a, b,
      output ready, busy, done, result, state
   );

endinterface

// File: rtl/shift_add_multiplier_shifters.sv
// Logical left/right shifters from the shifter library, used by the multiplier datapath.
module sll #(
   parameter int N = 32
) (
   input  logic [N-1:0]         data_i,
   input  logic [$clog2(N)-1:0] shamt_i,
   output logic [N-1:0]         data_o
);
   assign data_o = data_i << shamt_i;
endmodule

module srl #(
   parameter int N = 32
) (
   input  logic [N-1:0]         data_i,
   input  logic [$clog2(N)-1:0] shamt_i,
   output logic [N-1:0]         data_o
);
   assign data_o = data_i >> shamt_i;
endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned N x N -> 2N shift-add multiplier (IDLE/BUSY/DONE).
// Define SHIFT_MULT_EARLY_EXIT_EN to leave BUSY as soon as the multiplier runs out of set bits.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   shift_add_multiplier_if.slave   bus
);

   localparam int W2  = 2 * N;
   localparam int CW  = $clog2(N);
   localparam int MSW = $clog2(W2);
   localparam logic [MSW-1:0] SHAMT_MC = MSW'(MULT_SHAMT_ONE);
   localparam logic [CW-1:0]  SHAMT_MP = CW'(MULT_SHAMT_ONE);
   localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);

   mult_state_t      state_q, state_d;
   logic [W2-1:0]    mcand_q;
   logic [W2-1:0]    mcand_sll;
   logic [N-1:0]     mplr_q;
   logic [N-1:0]     mplr_srl;
   logic [W2-1:0]    acc_q;
   logic [CW-1:0]    count_q;
   logic             mplr_zero;

   sll #(.N(W2)) u_sll (
      .data_i  (mcand_q),
      .shamt_i (SHAMT_MC),
      .data_o  (mcand_sll)
   );

   srl #(.N(N)) u_srl (
      .data_i  (mplr_q),
      .shamt_i (SHAMT_MP),
      .data_o  (mplr_srl)
   );

`ifdef SHIFT_MULT_EARLY_EXIT_EN
   assign mplr_zero = (mplr_q == '0);
`else
   assign mplr_zero = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  mcand_q <= {{N{1'b0}}, bus.a};
                  mplr_q  <= bus.b;
                  acc_q   <= '0;
                  count_q <= '0;
               end
            end
            S_BUSY: begin
               // With early exit, an exhausted multiplier leaves acc untouched.
               if (!mplr_zero) begin
                  if (mplr_q[0]) begin
                     acc_q <= acc_q + mcand_q;
                  end
                  mcand_q <= mcand_sll;
                  mplr_q  <= mplr_srl;
                  count_q <= count_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      bus.ready  = 1'b0;
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.result = acc_q;
      bus.state  = state_q;
      case (state_q)
         S_IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) begin
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            bus.busy = 1'b1;
            if (mplr_zero || (count_q == LAST_CNT)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: driver pushes expected products, monitor pops on done.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [2*N-1:0] exp_q[$];
  int             lat_q[$];
  int             n_checks = 0;
  int             n_fail = 0;
  int             cyc = 0;
  int             accept_cyc = 0;
  int             n_accept = 0;
  int             n_done = 0;
  int             n_aborted = 0;
  bit             last_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef SHIFT_MULT_EARLY_EXIT_EN
    int msb;
    if (b == '0) return 2;
    msb = 0;
    for (int i = 0; i < N; i++) if (b[i]) msb = i;
    return (msb + 3 < N + 1) ? msb + 3 : N + 1;
`else
    return N + 1;
`endif
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      last_done = 1'b0;
    end else begin
      check("status_onehot", 64'($countones({bus.ready, bus.busy, bus.done})), 64'd1);
      if (last_done) begin
        check("done_width", 64'(bus.done), 64'd0);
        check("ready_after_done", 64'(bus.ready), 64'd1);
      end
      if (bus.ready && bus.start) begin
        accept_cyc = cyc;
        n_accept++;
      end
      if (bus.done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          check("result", bus.result, exp_q.pop_front());
          check("latency", 64'(cyc - accept_cyc), 64'(lat_q.pop_front()));
        end
      end
      last_done = bus.done;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait", 64'(bus.ready), 64'd1);
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] p);
    @(posedge clk); #1;
    wait_ready();
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    exp_q.push_back(p);
    lat_q.push_back(exp_lat(b));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(bus.state), 64'(S_IDLE));
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", bus.result, 64'd0);
    rst = 1'b0;

    // Directed vectors with hand-computed products.
    issue(32'd3, 32'd5, 64'd15);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    issue(32'h80000000, 32'h80000000, 64'h40000000_00000000);
    issue(32'h00001234, 32'd0, 64'd0);
    issue(32'd0, 32'h00003039, 64'd0);
    issue(32'hABCDEF01, 32'd1, 64'h00000000_ABCDEF01);
    issue(32'd1, 32'h80000000, 64'h00000000_80000000);
    issue(32'd10, 32'd10, 64'd100);
    issue(32'h00010000, 32'h00010000, 64'h00000001_00000000);
    drain();

    // Result holds through IDLE.
    repeat (3) @(posedge clk);
    #1;
    check("result_hold", bus.result, 64'h00000001_00000000);

    // start held high through BUSY with new operands: second op accepted only on IDLE.
    @(posedge clk); #1;
    wait_ready();
    bus.start = 1'b1;
    bus.a = 32'd11;
    bus.b = 32'd13;
    exp_q.push_back(64'd143);
    lat_q.push_back(exp_lat(32'd13));
    @(posedge clk); #1;
    bus.a = 32'd100;
    bus.b = 32'd200;
    exp_q.push_back(64'd20000);
    lat_q.push_back(exp_lat(32'd200));
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    wait_ready();
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("second_accepted", 64'(bus.busy), 64'd1);
    drain();

    // Asynchronous reset in the middle of iteration 10.
    @(posedge clk); #1;
    wait_ready();
    bus.start = 1'b1;
    bus.a = 32'hDEADBEEF;
    bus.b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_aborted++;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_state", 64'(bus.state), 64'(S_IDLE));
    check("midrst_result", bus.result, 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_ready", 64'(bus.ready), 64'd1);
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(32'd7, 32'd6, 64'd42);
    drain();

    // Random operands checked against a full-width product.
    for (int i = 0; i < 100; i++) begin
      ra = N'($urandom());
      rb = N'($urandom());
      if (i % 10 == 0) rb = N'($urandom_range(0, 255));
      issue(ra, rb, 64'(ra) * 64'(rb));
    end
    drain();

    repeat (3) @(posedge clk);
    check("done_count", 64'(n_done), 64'(n_accept - n_aborted));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
